word_count_path: RTL and testbench

//  Word-count slice of the Am2940-style DMA generator; companion to address_path.

---
 rtl/word_count_path.sv | 85 ++++++++
 tb/tb_word_count_path.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/word_count_path.sv
// Word-count slice of an Am2940-style DMA generator: counts words, flags done.
// Build option WC_AUTO_RELOAD_EN: reload on terminal count, done becomes a pulse.
module word_count_path #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             plwr,
    input  logic             plwc,
    input  logic             selw,
    input  logic             enw,
    input  logic             decw,
    input  logic             wci,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] bus_data_in,
    output logic [WIDTH-1:0] word_count_out,
    output logic             wco,
    output logic             done
);

    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step;
    logic             count;
    logic             term;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        count  = enw & wci & ~plwc;
        step   = decw ? cnt_q - 1'b1 : cnt_q + 1'b1;
        term   = 1'b0;

        if (plwr)
            word_d = bus_data_in;

        // compare mode looks at the register value after this edge
        if (count) begin
            case (mode)
                2'b00:   term = (step == '0);
                2'b01:   term = (step == word_d);
                default: term = 1'b0;
            endcase
        end

        if (plwc)
            cnt_d = selw ? word_q : bus_data_in;
        else if (count) begin
`ifdef WC_AUTO_RELOAD_EN
            cnt_d = term ? word_d : step;
`else
            cnt_d = step;
`endif
        end

`ifdef WC_AUTO_RELOAD_EN
        done_d = term & ~plwc;
`else
        if (plwc)
            done_d = 1'b0;
        else if (term)
            done_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            word_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign word_count_out = cnt_q;
    assign done           = done_q;
    assign wco = enw & wci &
                 (decw ? (cnt_q == '0) : (cnt_q == {WIDTH{1'b1}}));

endmodule

// File: tb/tb_word_count_path.sv
// Directed bench for word_count_path (WIDTH=4), scoreboard of expected
// counter/done values, immediate-assertion checks.
module tb_word_count_path;

`ifdef WC_AUTO_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    typedef struct {
        string    tag;
        logic [3:0] cnt;
        logic     done;
    } exp_t;

    logic       clk;
    logic       res, plwr, plwc, selw, enw, decw, wci;
    logic [1:0] mode;
    logic [3:0] bus_data_in;
    logic [3:0] word_count_out;
    logic       wco, done;

    int   n_vec;
    int   n_err;
    exp_t sb[$];
    logic sd;

    word_count_path #(.WIDTH(4)) dut (
        .clk(clk), .res(res), .plwr(plwr), .plwc(plwc),
        .selw(selw), .enw(enw), .decw(decw), .wci(wci),
        .mode(mode), .bus_data_in(bus_data_in),
        .word_count_out(word_count_out), .wco(wco), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input string tag, input logic [3:0] c,
                        input logic d);
        exp_t e;
        e.tag = tag; e.cnt = c; e.done = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_vec++;
        assert (word_count_out === e.cnt) else begin
            n_err++;
            $error("FAIL %s cnt observed=%0d expected=%0d",
                   e.tag, word_count_out, e.cnt);
        end
        n_vec++;
        assert (done === e.done) else begin
            n_err++;
            $error("FAIL %s done observed=%0b expected=%0b",
                   e.tag, done, e.done);
        end
    endtask

    task automatic chk_wco(input string tag, input logic w);
        #1;
        n_vec++;
        assert (wco === w) else begin
            n_err++;
            $error("FAIL %s wco observed=%0b expected=%0b", tag, wco, w);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sd    = ~RELOAD;

        // reset with random other inputs
        res = 1'b1;
        plwr = 1'($urandom); plwc = 1'($urandom); selw = 1'($urandom);
        enw = 1'($urandom); decw = 1'($urandom); wci = 1'($urandom);
        mode = 2'($urandom); bus_data_in = 4'($urandom);
        tick("reset", 4'd0, 1'b0);

        res = 1'b0; plwr = 0; plwc = 0; selw = 0;
        enw = 1; decw = 1; wci = 1; mode = 2'b00; bus_data_in = 0;
        chk_wco("wco_dec_at_0", 1'b1);

        // countdown, mode 00
        enw = 0; plwr = 1; bus_data_in = 4'd3;
        tick("load_word3", 4'd0, 1'b0);
        plwr = 0; plwc = 1; selw = 1;
        tick("load_cnt3", 4'd3, 1'b0);
        plwc = 0; enw = 1; wci = 1; decw = 1;
        tick("dn_2", 4'd2, 1'b0);
        tick("dn_1", 4'd1, 1'b0);
        tick("dn_0", RELOAD ? 4'd3 : 4'd0, 1'b1);
        tick("dn_wrap", RELOAD ? 4'd2 : 4'd15, sd);
        tick("dn_14", RELOAD ? 4'd1 : 4'd14, sd);

        // compare, mode 01
        enw = 0; plwr = 1; bus_data_in = 4'd5; mode = 2'b01;
        tick("load_word5", RELOAD ? 4'd1 : 4'd14, sd);
        plwr = 0; plwc = 1; selw = 0; bus_data_in = 4'd2;
        tick("load_bus2", 4'd2, 1'b0);
        plwc = 0; enw = 1; wci = 1; decw = 0;
        tick("up_3", 4'd3, 1'b0);
        tick("up_4", 4'd4, 1'b0);
        tick("up_5", 4'd5, 1'b1);
        chk_wco("wco_at_5", 1'b0);
        for (int i = 6; i <= 15; i++)
            tick("up_run", 4'(i), sd);
        chk_wco("wco_at_15", 1'b1);
        tick("up_wrap", 4'd0, sd);

        // hold and priority
        wci = 0;
        chk_wco("wco_wci0", 1'b0);
        tick("hold", 4'd0, sd);
        wci = 1; plwc = 1; selw = 0; bus_data_in = 4'd9;
        tick("load_wins", 4'd9, 1'b0);
        plwr = 1; bus_data_in = 4'd7; selw = 1;
        tick("old_word", 4'd5, 1'b0);
        plwr = 0;
        tick("new_word", 4'd7, 1'b0);

        // wrap, mode none
        mode = 2'b10; selw = 0; bus_data_in = 4'd15;
        tick("load15", 4'd15, 1'b0);
        plwc = 0; decw = 0;
        chk_wco("wco_inc_15", 1'b1);
        tick("inc_wrap", 4'd0, 1'b0);
        decw = 1;
        tick("dec_wrap", 4'd15, 1'b0);
        tick("dec_14", 4'd14, 1'b0);

        // reset mid-transfer
        res = 1;
        tick("mid_reset", 4'd0, 1'b0);
        res = 0;
        chk_wco("wco_after_rst", 1'b1);

`ifdef WC_AUTO_RELOAD_EN
        enw = 0; plwr = 1; bus_data_in = 4'd2; mode = 2'b00;
        tick("rl_word2", 4'd0, 1'b0);
        plwr = 0; plwc = 1; selw = 1;
        tick("rl_load", 4'd2, 1'b0);
        plwc = 0; enw = 1;
        tick("rl_1a", 4'd1, 1'b0);
        tick("rl_2a", 4'd2, 1'b1);
        tick("rl_1b", 4'd1, 1'b0);
        tick("rl_2b", 4'd2, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
